// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and fetch constants.
package if_stage_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFault = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/full_adder_16bit.sv
// 16-bit ripple-carry adder built from a chain of single-bit full adders.
module full_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [16:0] carry;

    always_comb begin
        carry[0] = c_in;
        sum      = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = carry[16];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and feeds
// decode through a registered IF/ID slot with a valid/ready handshake.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INSTR_W  = 32,
    parameter int unsigned     ROM_AW   = 14,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_plus4,
    output logic               fault
);

    if_state_e       state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next_seq;
    logic            pc_carry_unused;

    // Carry out is dropped so 16'hFFFC + 4 wraps to zero.
    full_adder_16bit u_pc_inc (
        .a     (pc),
        .b     (16'd4),
        .c_in  (1'b0),
        .sum   (pc_next_seq),
        .c_out (pc_carry_unused)
    );

    assign rom_addr = pc[PC_W-1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StBoot;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            fault       <= 1'b0;
        end else begin
            case (state)
                StBoot: begin
                    state <= StRun;
                end
                StRun: begin
                    if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
                        // Flush the slot; a pending handshake this edge still completes.
                        pc       <= redirect_pc;
                        id_valid <= 1'b0;
                        id_instr <= NOP;
                    end else if (redirect_valid) begin
                        fault    <= 1'b1;
                        id_valid <= 1'b0;
                        state    <= StFault;
                    end else if (!id_valid || id_ready) begin
                        id_instr    <= rom_data;
                        id_pc       <= pc;
                        id_pc_plus4 <= pc_next_seq;
                        id_valid    <= 1'b1;
                        pc          <= pc_next_seq;
                    end
                end
                StFault: begin
                    id_valid <= 1'b0;
                    fault    <= 1'b1;
                end
                default: begin
                    state <= StBoot;
                end
            endcase
        end
    end

endmodule
